// File: rtl/log2_round_pipe.sv
//==============================================================================
// Module      : log2_round_pipe
// Description : Two-stage valid/ready pipeline that rounds an unsigned operand
//               to a power of two (floor, half-up or ceiling) and returns the
//               rounded value, its exponent, a zero flag and a sideband tag.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module log2_round_pipe #(
  parameter int WIDTH      = 16,
  parameter int LOG2_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      IN,
  input  logic [1:0]            mode,
  input  logic [7:0]            in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH:0]        IN_r,
  output logic [LOG2_WIDTH:0]   exp_out,
  output logic                  zero_out,
  output logic [7:0]            out_tag
);

  localparam logic [1:0] c_MODE_FLOOR = 2'b00;
  localparam logic [1:0] c_MODE_CEIL  = 2'b10;

  // Stage 1: raw operand plus the MSB position and zero flag
  logic                  r_s1_valid;
  logic [WIDTH-1:0]      r_s1_in;
  logic [1:0]            r_s1_mode;
  logic [7:0]            r_s1_tag;
  logic [LOG2_WIDTH-1:0] r_s1_k;
  logic                  r_s1_zero;

  // Stage 2: final results, which drive the outputs directly
  logic                  r_s2_valid;
  logic [WIDTH:0]        r_s2_pow;
  logic [LOG2_WIDTH:0]   r_s2_exp;
  logic                  r_s2_zero;
  logic [7:0]            r_s2_tag;

  logic                  w_s2_load;
  logic                  w_s1_adv;
  logic                  w_s1_load;
  logic [LOG2_WIDTH-1:0] w_k;
  logic                  w_zero;
  logic [WIDTH-1:0]      w_low_mask;
  logic [WIDTH-1:0]      w_half_mask;
  logic                  w_any_below;
  logic                  w_half_bit;
  logic                  w_up;
  logic [LOG2_WIDTH:0]   w_exp;
  logic [WIDTH:0]        w_pow;

  // Handshake: S2 frees when empty or drained; S1 frees when empty or moving on.
  // in_ready therefore depends on out_ready but never on in_valid.
  assign w_s2_load = ~r_s2_valid | out_ready;
  assign w_s1_adv  = r_s1_valid & w_s2_load;
  assign in_ready  = ~r_s1_valid | w_s1_adv;
  assign w_s1_load = in_valid & in_ready;

  // Priority encoder: the highest set bit wins because it is visited last
  always_comb begin
    w_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (IN[i]) w_k = LOG2_WIDTH'(i);
    end
  end

  assign w_zero = ~|IN;

  // Bits strictly below the MSB, and the single bit just below it (k-1).
  // For k=0 both masks are empty, so no mode can round up.
  assign w_low_mask  = (WIDTH'(1) << r_s1_k) - WIDTH'(1);
  assign w_half_mask = w_low_mask ^ (w_low_mask >> 1);
  assign w_any_below = |(r_s1_in & w_low_mask);
  assign w_half_bit  = |(r_s1_in & w_half_mask);

  // Rounding decision and result formation from the S1 contents
  always_comb begin
    w_up  = 1'b0;
    w_exp = '0;
    w_pow = '0;
    case (r_s1_mode)
      c_MODE_FLOOR: w_up = 1'b0;
      c_MODE_CEIL:  w_up = w_any_below;
      default:      w_up = w_half_bit;
    endcase
    if (!r_s1_zero) begin
      w_exp = {1'b0, r_s1_k} + {{LOG2_WIDTH{1'b0}}, w_up};
      // Bit WIDTH of the result carries a round-up out of the top position
      w_pow = (WIDTH+1)'(1) << w_exp;
    end
  end

  // Stage 1 register: capture operand and encoder results on an input transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_in    <= '0;
      r_s1_mode  <= '0;
      r_s1_tag   <= '0;
      r_s1_k     <= '0;
      r_s1_zero  <= 1'b0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_s1_load) begin
        r_s1_in   <= IN;
        r_s1_mode <= mode;
        r_s1_tag  <= in_tag;
        r_s1_k    <= w_k;
        r_s1_zero <= w_zero;
      end
    end
  end

  // Stage 2 register: holds its contents while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_pow   <= '0;
      r_s2_exp   <= '0;
      r_s2_zero  <= 1'b0;
      r_s2_tag   <= '0;
    end else begin
      if (w_s2_load) r_s2_valid <= r_s1_valid;
      if (w_s1_adv) begin
        r_s2_pow  <= w_pow;
        r_s2_exp  <= w_exp;
        r_s2_zero <= r_s1_zero;
        r_s2_tag  <= r_s1_tag;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign IN_r      = r_s2_pow;
  assign exp_out   = r_s2_exp;
  assign zero_out  = r_s2_zero;
  assign out_tag   = r_s2_tag;

endmodule

`default_nettype wire

// File: tb/tb_log2_round_pipe.sv
//==============================================================================
// Module      : tb_log2_round_pipe
// Description : Self-checking bench for log2_round_pipe: arithmetic reference
//               model, in-order scoreboard, stall stability and ready checks.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_log2_round_pipe;

  localparam int WIDTH      = 16;
  localparam int LOG2_WIDTH = 4;
  localparam int c_HW       = WIDTH + LOG2_WIDTH + 12;

  typedef struct packed {
    logic [WIDTH:0]      r;
    logic [LOG2_WIDTH:0] e;
    logic                z;
    logic [7:0]          tag;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0]    v;
    logic [1:0]          m;
    logic [WIDTH:0]      r;
    logic [LOG2_WIDTH:0] e;
    logic                z;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [WIDTH-1:0]    IN = '0;
  logic [1:0]          mode = '0;
  logic [7:0]          in_tag = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [WIDTH:0]      IN_r;
  logic [LOG2_WIDTH:0] exp_out;
  logic                zero_out;
  logic [7:0]          out_tag;

  exp_t            q[$];
  int              n_vec = 0;
  int              n_err = 0;
  bit              rnd_ready = 1'b0;
  bit              stalled = 1'b0;
  logic [c_HW-1:0] held;

  log2_round_pipe #(.WIDTH(WIDTH), .LOG2_WIDTH(LOG2_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .IN(IN), .mode(mode), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .IN_r(IN_r), .exp_out(exp_out),
    .zero_out(zero_out), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Reference: floor power p = 2^k, remainder rem = v - p.
  // Half-up rounds when rem >= p/2 (k>0), ceiling when rem != 0.
  function automatic exp_t ref_calc(input logic [WIDTH-1:0] v, input logic [1:0] m,
                                    input logic [7:0] tag);
    exp_t              x;
    longint unsigned   vv, p, rem;
    int                k;
    bit                up;
    x.tag = tag;
    if (v == '0) begin
      x.r = '0; x.e = '0; x.z = 1'b1;
      return x;
    end
    vv = longint'(v);
    k = 0;
    for (int i = 0; i < WIDTH; i++) if (v[i]) k = i;
    p   = 64'd1 << k;
    rem = vv - p;
    case (m)
      2'd0:    up = 1'b0;
      2'd2:    up = (rem != 0);
      default: up = (k > 0) && (rem >= p / 2);
    endcase
    x.r = (WIDTH+1)'(up ? p * 2 : p);
    x.e = (LOG2_WIDTH+1)'(k + (up ? 1 : 0));
    x.z = 1'b0;
    return x;
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Compare process: one transfer decision per cycle, evaluated mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        n_vec++;
        if ({out_valid, IN_r, exp_out, zero_out, out_tag} !== held) begin
          n_err++;
          $display("FAIL stall_hold: got 0x%0h, expected 0x%0h",
                   {out_valid, IN_r, exp_out, zero_out, out_tag}, held);
        end
      end
      n_vec++;
      if (in_ready !== !(q.size() == 2 && !out_ready)) begin
        n_err++;
        $display("FAIL in_ready: got %0b, expected %0b (occupancy %0d, out_ready %0b)",
                 in_ready, !(q.size() == 2 && !out_ready), q.size(), out_ready);
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_output: got tag 0x%0h, expected no output", out_tag);
        end else begin
          e = q.pop_front();
          if ({IN_r, exp_out, zero_out, out_tag} !== e) begin
            n_err++;
            $display("FAIL result: got r=0x%0h e=%0d z=%0b tag=0x%0h, expected r=0x%0h e=%0d z=%0b tag=0x%0h",
                     IN_r, exp_out, zero_out, out_tag, e.r, e.e, e.z, e.tag);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(ref_calc(IN, mode, in_tag));
      stalled = out_valid && !out_ready;
      held    = {out_valid, IN_r, exp_out, zero_out, out_tag};
    end
  end

  // Present one transaction and hold it until it is taken; leaves at posedge+1
  task automatic send(input logic [WIDTH-1:0] v, input logic [1:0] m, input logic [7:0] t);
    int guard = 0;
    bit done  = 1'b0;
    in_valid = 1'b1; IN = v; mode = m; in_tag = t;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 99) < 60);
      guard++;
      if (!done && guard > 1000) begin
        n_err++;
        $display("FAIL send_timeout: got no acceptance in %0d cycles, expected acceptance", guard);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 99) < 60);
  endtask

  task automatic drain();
    int guard = 0;
    in_valid = 1'b0; rnd_ready = 1'b0; out_ready = 1'b1;
    while (q.size() > 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_empty", longint'(q.size()), 0);
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[16];
    exp_t x;
    int   cyc;
    tbl[0]  = '{16'h0006, 2'd1, 17'h00008, 5'd3,  1'b0};
    tbl[1]  = '{16'h0004, 2'd1, 17'h00004, 5'd2,  1'b0};
    tbl[2]  = '{16'h8001, 2'd0, 17'h08000, 5'd15, 1'b0};
    tbl[3]  = '{16'h8001, 2'd1, 17'h08000, 5'd15, 1'b0};
    tbl[4]  = '{16'h8001, 2'd2, 17'h10000, 5'd16, 1'b0};
    tbl[5]  = '{16'hFFFF, 2'd1, 17'h10000, 5'd16, 1'b0};
    tbl[6]  = '{16'h0000, 2'd0, 17'h00000, 5'd0,  1'b1};
    tbl[7]  = '{16'h0000, 2'd3, 17'h00000, 5'd0,  1'b1};
    tbl[8]  = '{16'h0001, 2'd2, 17'h00001, 5'd0,  1'b0};
    tbl[9]  = '{16'h0001, 2'd3, 17'h00001, 5'd0,  1'b0};
    tbl[10] = '{16'h0005, 2'd2, 17'h00008, 5'd3,  1'b0};
    tbl[11] = '{16'h0004, 2'd2, 17'h00004, 5'd2,  1'b0};
    tbl[12] = '{16'h0003, 2'd0, 17'h00002, 5'd1,  1'b0};
    tbl[13] = '{16'h0003, 2'd3, 17'h00004, 5'd2,  1'b0};
    tbl[14] = '{16'hC000, 2'd1, 17'h10000, 5'd16, 1'b0};
    tbl[15] = '{16'h4000, 2'd2, 17'h04000, 5'd14, 1'b0};

    // Reset state
    #12;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_IN_r", longint'(IN_r), 0);
    check("rst_exp_out", longint'(exp_out), 0);
    check("rst_zero_out", longint'(zero_out), 0);
    check("rst_out_tag", longint'(out_tag), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", longint'(in_ready), 1);

    // Latency with an empty pipe and out_ready held high
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; IN = 16'h0006; mode = 2'd1; in_tag = 8'h55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency_edges", longint'(cyc), 2);
    check("latency_IN_r", longint'(IN_r), 64'h8);
    check("latency_exp", longint'(exp_out), 3);
    drain();

    // Directed vectors: pin the model to hand values, then stream to the DUT
    for (int i = 0; i < 16; i++) begin
      x = ref_calc(tbl[i].v, tbl[i].m, 8'(i));
      check("model_vs_literal", longint'({x.r, x.e, x.z}), longint'({tbl[i].r, tbl[i].e, tbl[i].z}));
      send(tbl[i].v, tbl[i].m, 8'(i));
    end
    drain();

    // Tag ordering under random back-pressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(16'(($urandom_range(0, 65535))), 2'(i), 8'(i));
    drain();

    // Reset with two transactions in flight
    out_ready = 1'b0;
    send(16'h0100, 2'd0, 8'hA0);
    send(16'h0300, 2'd2, 8'hA1);
    check("full_out_valid", longint'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_IN_r", longint'(IN_r), 0);
    check("midrst_out_tag", longint'(out_tag), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midrst", longint'(in_ready), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'h0007, 2'd1, 8'hA2);
    drain();

    // Random operands, modes, bubbles and back-pressure
    rnd_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 4) == 0) idle();
      send(16'($urandom) >> $urandom_range(0, WIDTH - 1), 2'($urandom_range(0, 3)), 8'(n));
    end
    drain();
    @(negedge clk);
    check("final_out_valid", longint'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
